// File: rtl/db_stream_pkg.sv
// Shared constants for the double-buffered tile stream controller.
package db_stream_pkg;
    localparam logic [1:0] FIFO_DEPTH = 2'd2;
    localparam int         TILE_CNT_W = 16;
endpackage

// File: rtl/mem_db.sv
// Two-bank ping-pong memory: sw selects which bank is written and which is read.
// Read data is registered and appears the cycle after ren.
module mem_db #(
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 1024,
    parameter int ADDR_BIT = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                sw,
    input  logic                wen,
    input  logic [ADDR_BIT-1:0] waddr,
    input  logic [DATA_BIT-1:0] wdata,
    input  logic                ren,
    input  logic [ADDR_BIT-1:0] raddr,
    output logic [DATA_BIT-1:0] rdata
);
    logic [DATA_BIT-1:0] bank0 [DEPTH];
    logic [DATA_BIT-1:0] bank1 [DEPTH];

    // sw=0: write bank1 / read bank0; sw=1: write bank0 / read bank1.
    always_ff @(posedge clk) begin
        if (wen) begin
            if (sw) bank0[waddr] <= wdata;
            else    bank1[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= sw ? bank1[raddr] : bank0[raddr];
        end
    end
endmodule

// File: rtl/db_stream_ctrl.sv
// Ping-pong tile stream controller: fills one bank from the input stream while
// draining the other bank to the output stream, swapping banks per tile.
module db_stream_ctrl
    import db_stream_pkg::*;
#(
    parameter int DATA_BIT = 64,
    parameter int DEPTH    = 1024,
    parameter int ADDR_BIT = $clog2(DEPTH),
    parameter int TILE_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BIT-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_BIT-1:0]   out_data,
    output logic                  out_last,
    output logic                  swap,
    output logic [TILE_CNT_W-1:0] tile_cnt
);
    localparam logic [ADDR_BIT-1:0] LAST_ADDR  = ADDR_BIT'(TILE_LEN - 1);
    localparam logic [ADDR_BIT:0]   TILE_WORDS = (ADDR_BIT + 1)'(TILE_LEN);

    logic                  sw_q, sw_d;
    logic [ADDR_BIT-1:0]   wr_ptr_q, wr_ptr_d;
    logic                  wr_full_q, wr_full_d;
    logic                  rd_active_q, rd_active_d;
    logic [ADDR_BIT:0]     rd_cnt_q, rd_cnt_d;
    logic                  delivered_q, delivered_d;
    logic                  inflight_q, inflight_last_q;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;
    logic                  fifo_rd_q, fifo_rd_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic [DATA_BIT-1:0]   fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic [TILE_CNT_W-1:0] tile_cnt_q, tile_cnt_d;

    logic                  wen, ren, pop, last_pop, push, fifo_pop, fifo_has;
    logic                  reader_done;
    logic [1:0]            occupancy;
    logic [ADDR_BIT-1:0]   raddr;
    logic [DATA_BIT-1:0]   rdata;

    mem_db #(
        .DATA_BIT (DATA_BIT),
        .DEPTH    (DEPTH),
        .ADDR_BIT (ADDR_BIT)
    ) u_mem (
        .clk   (clk),
        .sw    (sw_q),
        .wen   (wen),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign in_ready = !wr_full_q && !rst;
    assign wen      = in_valid && in_ready;

    // Fall-through output: a word returning from memory is presented the same
    // cycle it arrives when the FIFO is empty, and parked in the FIFO otherwise.
    assign fifo_has  = (fifo_cnt_q != 2'd0);
    assign out_valid = fifo_has || inflight_q;
    assign out_data  = fifo_has ? fifo_data_q[fifo_rd_q] : rdata;
    assign out_last  = fifo_has ? fifo_last_q[fifo_rd_q] : inflight_last_q;
    assign pop       = out_valid && out_ready;
    assign last_pop  = pop && out_last;
    assign fifo_pop  = pop && fifo_has;
    assign push      = inflight_q && !(pop && !fifo_has);

    // Counting the final handshake combinationally keeps the swap stall at one cycle.
    assign reader_done = !rd_active_q || delivered_q || last_pop;
    assign swap        = wr_full_q && reader_done;

    assign occupancy = fifo_cnt_q + {1'b0, inflight_q};
    assign raddr     = rd_cnt_q[ADDR_BIT-1:0];
    assign ren       = rd_active_q && !swap && (rd_cnt_q != TILE_WORDS)
                       && (occupancy < FIFO_DEPTH);
    assign tile_cnt  = tile_cnt_q;

    always_comb begin
        sw_d        = sw_q;
        wr_ptr_d    = wr_ptr_q;
        wr_full_d   = wr_full_q;
        rd_active_d = rd_active_q;
        rd_cnt_d    = rd_cnt_q;
        delivered_d = delivered_q;
        tile_cnt_d  = tile_cnt_q;
        fifo_rd_d   = fifo_rd_q ^ fifo_pop;
        fifo_wr_d   = fifo_wr_q ^ push;

        case ({push, fifo_pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (wen) begin
            if (wr_ptr_q == LAST_ADDR) begin
                wr_ptr_d  = '0;
                wr_full_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_BIT'(1);
            end
        end
        if (ren) begin
            rd_cnt_d = rd_cnt_q + (ADDR_BIT + 1)'(1);
        end
        if (last_pop) begin
            delivered_d = 1'b1;
            tile_cnt_d  = tile_cnt_q + TILE_CNT_W'(1);
        end
        if (swap) begin
            sw_d        = !sw_q;
            wr_full_d   = 1'b0;
            rd_active_d = 1'b1;
            rd_cnt_d    = '0;
            delivered_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_q            <= 1'b0;
            wr_ptr_q        <= '0;
            wr_full_q       <= 1'b0;
            rd_active_q     <= 1'b0;
            rd_cnt_q        <= '0;
            delivered_q     <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_cnt_q      <= 2'd0;
            fifo_rd_q       <= 1'b0;
            fifo_wr_q       <= 1'b0;
            tile_cnt_q      <= '0;
        end else begin
            sw_q            <= sw_d;
            wr_ptr_q        <= wr_ptr_d;
            wr_full_q       <= wr_full_d;
            rd_active_q     <= rd_active_d;
            rd_cnt_q        <= rd_cnt_d;
            delivered_q     <= delivered_d;
            inflight_q      <= ren;
            inflight_last_q <= ren && (raddr == LAST_ADDR);
            fifo_cnt_q      <= fifo_cnt_d;
            fifo_rd_q       <= fifo_rd_d;
            fifo_wr_q       <= fifo_wr_d;
            tile_cnt_q      <= tile_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[fifo_wr_q] <= rdata;
            fifo_last_q[fifo_wr_q] <= inflight_last_q;
        end
    end

    a_no_wen_full: assert property (@(posedge clk) disable iff (rst) !(wen && wr_full_q));
    a_no_ren_idle: assert property (@(posedge clk) disable iff (rst) ren |-> rd_active_q);
    a_sw_on_swap:  assert property (@(posedge clk) disable iff (rst)
                       (sw_q != $past(sw_q)) |-> ($past(swap) || $past(rst)));
endmodule

// File: tb/tb_db_stream_ctrl.sv
// Directed bench for db_stream_ctrl: a TILE_LEN=4 instance and a full-bank
// TILE_LEN=DEPTH=16 instance, checked against a word queue and hand-derived timing.
module tb_db_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, out_last4, swap4;
    logic [63:0] in_data4, out_data4;
    logic [15:0] tile_cnt4;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, swap16;
    logic [63:0] in_data16, out_data16;
    logic [15:0] tile_cnt16;

    int          n_total = 0, n_pass = 0, n_fail = 0;
    logic [63:0] src_q[$];
    logic [63:0] exp_q[$];
    logic        sel, feed_en, prev_stall;
    logic [63:0] prev_data;
    int          tl, out_idx, cyc, n_out, n_swap, n_lo, n_acc;
    int          first_swap, first_valid, first_rdy;
    logic        s_irdy, s_ovalid, s_olast, s_swap;
    logic [63:0] s_odata;
    logic [15:0] s_tcnt;

    always #5 clk = ~clk;

    db_stream_ctrl #(.DATA_BIT(64), .DEPTH(16), .TILE_LEN(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_last(out_last4), .swap(swap4), .tile_cnt(tile_cnt4));

    db_stream_ctrl #(.DATA_BIT(64), .DEPTH(16), .TILE_LEN(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16),
        .out_last(out_last16), .swap(swap16), .tile_cnt(tile_cnt16));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic phase_start();
        cyc = 0; n_out = 0; n_swap = 0; n_lo = 0; n_acc = 0;
        first_swap = -1; first_valid = -1; first_rdy = -1;
    endtask

    // One clock cycle: drive the selected DUT, sample at the falling edge,
    // score handshakes, then step past the rising edge.
    task automatic tick(input logic orr);
        logic        iv;
        logic [63:0] exp;
        iv = feed_en && (src_q.size() != 0);
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
        if (sel) begin
            in_valid16 = iv; in_data16 = iv ? src_q[0] : 64'd0; out_ready16 = orr;
        end else begin
            in_valid4 = iv; in_data4 = iv ? src_q[0] : 64'd0; out_ready4 = orr;
        end
        @(negedge clk);
        s_irdy   = sel ? in_ready16  : in_ready4;
        s_ovalid = sel ? out_valid16 : out_valid4;
        s_odata  = sel ? out_data16  : out_data4;
        s_olast  = sel ? out_last16  : out_last4;
        s_swap   = sel ? swap16      : swap4;
        s_tcnt   = sel ? tile_cnt16  : tile_cnt4;
        if (!rst) begin
            if (prev_stall) begin
                check("hold_valid", {63'd0, s_ovalid}, 64'd1);
                check("hold_data", s_odata, prev_data);
            end
            if (iv && s_irdy) begin
                exp_q.push_back(src_q.pop_front());
                n_acc++;
            end
            if (s_ovalid && first_valid < 0) first_valid = cyc;
            if (s_ovalid && orr) begin
                if (exp_q.size() == 0) begin
                    check("out_extra", {63'd0, s_ovalid}, 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("out_data", s_odata, exp);
                    check("out_last", {63'd0, s_olast}, {63'd0, (out_idx % tl) == tl - 1});
                end
                out_idx++;
                n_out++;
            end
            if (s_swap) begin
                n_swap++;
                if (first_swap < 0) first_swap = cyc;
            end
            if (!s_irdy) n_lo++;
            if (s_irdy && first_rdy < 0) first_rdy = cyc;
            prev_stall = s_ovalid && !orr;
            prev_data  = s_odata;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; feed_en = 1'b0; prev_stall = 1'b0; prev_data = '0;
        tl = 4; out_idx = 0;
        in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
        phase_start();
        @(posedge clk);
        #1;

        // Reset values
        tick(1'b0);
        check("rst_in_ready_low", {63'd0, s_irdy}, 64'd0);
        rst = 1'b0;
        tick(1'b0);
        check("rst_in_ready", {63'd0, s_irdy}, 64'd1);
        check("rst_out_valid", {63'd0, s_ovalid}, 64'd0);
        check("rst_out_last", {63'd0, s_olast}, 64'd0);
        check("rst_swap", {63'd0, s_swap}, 64'd0);
        check("rst_tile_cnt", {48'd0, s_tcnt}, 64'd0);

        // Single tile 0x10..0x13: swap at cycle 4, first output at cycle 6
        phase_start();
        for (int i = 0; i < 4; i++) src_q.push_back(64'h10 + 64'(i));
        feed_en = 1'b1;
        for (int i = 0; i < 12; i++) tick(1'b1);
        check("t1_words", 64'(n_out), 64'd4);
        check("t1_swaps", 64'(n_swap), 64'd1);
        check("t1_swap_cyc", 64'(first_swap), 64'd4);
        check("t1_first_valid", 64'(first_valid), 64'd6);
        check("t1_tile_cnt", {48'd0, s_tcnt}, 64'd1);

        // Three tiles back to back: one in_ready stall per swap
        phase_start();
        for (int i = 0; i < 12; i++) src_q.push_back(64'h20 + 64'(i));
        for (int i = 0; i < 24; i++) tick(1'b1);
        check("t2_words", 64'(n_out), 64'd12);
        check("t2_swaps", 64'(n_swap), 64'd3);
        check("t2_in_ready_low", 64'(n_lo), 64'd3);
        check("t2_tile_cnt", {48'd0, s_tcnt}, 64'd4);

        // Back-pressure 1,0,0,1
        phase_start();
        for (int i = 0; i < 8; i++) src_q.push_back(64'h30 + 64'(i));
        for (int i = 0; i < 40; i++) tick((i % 4 == 0) || (i % 4 == 3));
        check("t3_words", 64'(n_out), 64'd8);
        check("t3_swaps", 64'(n_swap), 64'd2);
        check("t3_tile_cnt", {48'd0, s_tcnt}, 64'd6);

        // Both banks full with output stalled
        phase_start();
        for (int i = 0; i < 8; i++) src_q.push_back(64'h40 + 64'(i));
        for (int i = 0; i < 12; i++) tick(1'b0);
        check("t4_accepted", 64'(n_acc), 64'd8);
        check("t4_in_ready_low", 64'(n_lo), 64'd4);
        check("t4_in_ready_end", {63'd0, s_irdy}, 64'd0);
        phase_start();
        for (int i = 0; i < 12; i++) tick(1'b1);
        check("t4_swap_cyc", 64'(first_swap), 64'd3);
        check("t4_ready_rise", 64'(first_rdy), 64'd4);
        check("t4_words", 64'(n_out), 64'd8);
        check("t4_tile_cnt", {48'd0, s_tcnt}, 64'd8);

        // Reset mid-drain after two of four words
        phase_start();
        for (int i = 0; i < 4; i++) src_q.push_back(64'h50 + 64'(i));
        for (int k = 0; k < 20 && n_out < 2; k++) tick(1'b1);
        check("t5_pre_words", 64'(n_out), 64'd2);
        rst = 1'b1; feed_en = 1'b0;
        tick(1'b0);
        rst = 1'b0;
        exp_q.delete(); src_q.delete(); out_idx = 0;
        check("t5_sw", {63'd0, u_dut4.sw_q}, 64'd0);
        tick(1'b0);
        check("t5_out_valid", {63'd0, s_ovalid}, 64'd0);
        check("t5_tile_cnt", {48'd0, s_tcnt}, 64'd0);
        check("t5_in_ready", {63'd0, s_irdy}, 64'd1);
        phase_start();
        for (int i = 0; i < 4; i++) src_q.push_back(64'hA0 + 64'(i));
        feed_en = 1'b1;
        for (int i = 0; i < 14; i++) tick(1'b1);
        check("t5_words", 64'(n_out), 64'd4);
        check("t5_swap_cyc", 64'(first_swap), 64'd4);
        check("t5_tile_cnt_after", {48'd0, s_tcnt}, 64'd1);

        // Full-bank tiles on the TILE_LEN=DEPTH=16 instance
        sel = 1'b1; tl = 16; out_idx = 0;
        phase_start();
        for (int i = 0; i < 32; i++) src_q.push_back(64'hC0 + 64'(i));
        for (int i = 0; i < 56; i++) tick(1'b1);
        check("t6_words", 64'(n_out), 64'd32);
        check("t6_swaps", 64'(n_swap), 64'd2);
        check("t6_first_valid", 64'(first_valid), 64'd18);
        check("t6_tile_cnt", {48'd0, s_tcnt}, 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
